// File: rtl/apb_demux4.sv
// APB 1-to-4 fan-out: decodes a 2-bit slot from PADDR, replays the transfer on the
// selected downstream port and returns its response, with wait-state timeout and unmapped-slot error.
module apb_demux4 #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_LSB = 6,
  parameter logic [3:0]  SLOT_EN = 4'b1111,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [3:0]          m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  input  logic [4*DATA_W-1:0] m_prdata,
  input  logic [3:0]          m_pready,
  input  logic [3:0]          m_pslverr
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DSETUP  = 2'd1,
    S_DACCESS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        slot_q, slot_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        psel_nxt;
  logic              penable_nxt;
  logic              pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic [DATA_W-1:0] prdata_nxt;
  logic              pready_nxt;
  logic              pslverr_nxt;

  logic [1:0]        req_slot;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout_hit;

  assign req_slot = PADDR[SEL_LSB +: 2];
  assign sel_ready = m_pready[slot_q];
  assign sel_err   = m_pslverr[slot_q];

  // Counter value in the final allowed access cycle; the abort fires if ready is still low there.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (slot_q == 2'(i)) sel_rdata = m_prdata[i*DATA_W +: DATA_W];
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot_q;
    cnt_nxt     = cnt;
    pwrite_nxt  = m_pwrite;
    paddr_nxt   = m_paddr;
    pwdata_nxt  = m_pwdata;
    prdata_nxt  = PRDATA;
    pslverr_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (SLOT_EN[req_slot]) begin
            state_nxt  = S_DSETUP;
            slot_nxt   = req_slot;
            paddr_nxt  = PADDR;
            pwrite_nxt = PWRITE;
            pwdata_nxt = PWDATA;
          end else begin
            state_nxt   = S_DONE;
            prdata_nxt  = '0;
            pslverr_nxt = 1'b1;
          end
        end
      end
      S_DSETUP: begin
        state_nxt = S_DACCESS;
        cnt_nxt   = '0;
      end
      S_DACCESS: begin
        if (sel_ready) begin
          state_nxt   = S_DONE;
          prdata_nxt  = m_pwrite ? '0 : sel_rdata;
          pslverr_nxt = sel_err;
        end else if (timeout_hit) begin
          state_nxt   = S_DONE;
          prdata_nxt  = '0;
          pslverr_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    psel_nxt    = ((state_nxt == S_DSETUP) || (state_nxt == S_DACCESS)) ? (4'b0001 << slot_nxt) : 4'b0000;
    penable_nxt = (state_nxt == S_DACCESS);
    pready_nxt  = (state_nxt == S_DONE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= S_IDLE;
      slot_q    <= 2'd0;
      cnt       <= '0;
      m_psel    <= 4'b0000;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_q    <= slot_nxt;
      cnt       <= cnt_nxt;
      m_psel    <= psel_nxt;
      m_penable <= penable_nxt;
      m_pwrite  <= pwrite_nxt;
      m_paddr   <= paddr_nxt;
      m_pwdata  <= pwdata_nxt;
      PRDATA    <= prdata_nxt;
      PREADY    <= pready_nxt;
      PSLVERR   <= pslverr_nxt;
    end
  end

endmodule

// File: tb/tb_apb_demux4.sv
// Bench for apb_demux4: upstream APB driver, per-slot downstream responder with noise
// on unselected slots, and a reference model feeding an expected-response queue.
module tb_apb_demux4;

  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 32;
  localparam int unsigned SEL_LSB = 6;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [3:0]  SLOT_EN = 4'b1011;
  localparam int          TO      = 15;
  localparam int          MAX_CYC = 60;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            PSEL = 1'b0;
  logic            PENABLE = 1'b0;
  logic            PWRITE = 1'b0;
  logic [AW-1:0]   PADDR = '0;
  logic [DW-1:0]   PWDATA = '0;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;
  logic [3:0]      m_psel;
  logic            m_penable;
  logic            m_pwrite;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata;
  logic [4*DW-1:0] m_prdata = '0;
  logic [3:0]      m_pready = '0;
  logic [3:0]      m_pslverr = '0;

  apb_demux4 #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SEL_LSB(SEL_LSB),
    .SLOT_EN(SLOT_EN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_prdata (m_prdata),
    .m_pready (m_pready),
    .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
    int            en_cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            xfer_id = 0;
  int            rsp_wait[4];
  logic          rsp_err[4];
  logic          rsp_hang[4];
  logic [DW-1:0] rsp_data[4];
  int            acc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Selected slot answers per its configuration; every other lane carries random noise.
  always @(negedge clk) begin
    m_pready  = 4'($urandom);
    m_pslverr = 4'($urandom);
    for (int i = 0; i < 4; i++) m_prdata[i*DW +: DW] = $urandom;
    if (m_penable) begin
      for (int i = 0; i < 4; i++) begin
        if (m_psel[i]) begin
          m_pready[i]           = !rsp_hang[i] && (acc >= rsp_wait[i]);
          m_pslverr[i]          = rsp_err[i];
          m_prdata[i*DW +: DW]  = rsp_data[i];
        end
      end
      acc++;
    end else begin
      acc = 0;
    end
  end

  task automatic set_rsp(input int s, input int w, input logic e, input logic h, input logic [DW-1:0] d);
    rsp_wait[s] = w;
    rsp_err[s]  = e;
    rsp_hang[s] = h;
    rsp_data[s] = d;
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata);
    exp_t e;
    int   s, eff, cyc, en_n, sel_n, bad;
    string id;
    s  = int'(addr[SEL_LSB +: 2]);
    id = $sformatf("t%0d", xfer_id);
    xfer_id++;
    if (!SLOT_EN[s]) begin
      e.rdata = '0; e.err = 1'b1; e.cyc = 1; e.en_cyc = 0;
    end else begin
      eff = rsp_hang[s] ? TO + 100 : rsp_wait[s];
      if (eff < TO) begin
        e.rdata = wr ? '0 : rsp_data[s];
        e.err = rsp_err[s]; e.cyc = 3 + eff; e.en_cyc = eff + 1;
      end else begin
        e.rdata = '0; e.err = 1'b1; e.cyc = TO + 2; e.en_cyc = TO;
      end
    end
    sb.push_back(e);

    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(posedge clk); #1;
    // Upstream address/data/direction change after capture must not leak downstream.
    PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~wdata; PWRITE = ~wr;
    cyc = 1; en_n = 0; sel_n = 0; bad = 0;
    while (1) begin
      if (m_penable) en_n++;
      if (m_psel != 4'b0000) begin
        sel_n++;
        if (m_psel != 4'(1 << s) || m_paddr != addr || m_pwrite != wr || m_pwdata != wdata) bad++;
      end
      if (PREADY || cyc >= MAX_CYC) break;
      @(posedge clk); #1;
      cyc++;
    end

    e = sb.pop_front();
    check({id, "_cycle"},   128'(cyc),     128'(e.cyc));
    check({id, "_rdata"},   128'(PRDATA),  128'(e.rdata));
    check({id, "_pslverr"}, 128'(PSLVERR), 128'(e.err));
    check({id, "_en_cyc"},  128'(en_n),    128'(e.en_cyc));
    check({id, "_sel_cyc"}, 128'(sel_n),   128'((e.en_cyc == 0) ? 0 : e.en_cyc + 1));
    check({id, "_bus_bad"}, 128'(bad),     128'(0));
    @(posedge clk); #1;
    check({id, "_pready_pulse"}, 128'(PREADY), 128'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) set_rsp(i, 0, 1'b0, 1'b0, 32'h1000_0000 + 32'(i));
    repeat (2) @(negedge clk);
    check("rst_outputs", 128'({PREADY, PSLVERR, PRDATA, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", 128'({PREADY, m_psel, m_penable}), 128'(0));

    set_rsp(1, 0, 1'b0, 1'b0, 32'h0BAD_F00D);
    xfer(8'h40, 1'b1, 32'hDEAD_BEEF);
    set_rsp(3, 3, 1'b0, 1'b0, 32'h1234_5678);
    xfer(8'hC4, 1'b0, 32'h0000_0000);
    xfer(8'h80, 1'b0, 32'h5555_AAAA);
    set_rsp(0, 0, 1'b0, 1'b1, 32'hCAFE_0000);
    xfer(8'h10, 1'b0, 32'h0);
    set_rsp(3, 1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    xfer(8'hC8, 1'b0, 32'h0);
    set_rsp(0, 14, 1'b0, 1'b0, 32'h7777_7777);
    xfer(8'h04, 1'b1, 32'h0102_0304);
    set_rsp(1, 15, 1'b0, 1'b0, 32'h8888_8888);
    xfer(8'h48, 1'b0, 32'h0);
    set_rsp(1, 2, 1'b0, 1'b0, 32'h3C3C_3C3C);
    xfer(8'h7F, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a downstream access phase.
    set_rsp(0, 0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h3C; PWRITE = 1'b1; PWDATA = 32'hFEED_FACE;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_access", 128'({m_psel, m_penable, m_pwrite, m_paddr}), 128'({4'b0001, 1'b1, 1'b1, 8'h3C}));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 128'({PREADY, PSLVERR, PRDATA, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}), 128'(0));
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_rsp(0, 0, 1'b0, 1'b0, 32'h0);

    set_rsp(1, 0, 1'b0, 1'b0, 32'h600D_D00D);
    xfer(8'h44, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
